// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: the stack op encoding driven by the AU and the overflow-mode selectors.
package ej32_pkg;

    typedef enum logic [1:0] {
        sNOP  = 2'd0,
        sPUSH = 2'd1,
        sPOP  = 2'd2,
        sMOVE = 2'd3
    } stack_op_t;

    localparam int WRAP_DROP = 0;
    localparam int WRAP_CIRC = 1;

endpackage

// File: rtl/ej32_ss_ram.sv
// Spill RAM for the data stack: one write port, one synchronous read port, no reset.
// Read-during-write to the same address returns the old contents.
module ej32_ss_ram #(
    parameter int DSZ      = 32,
    parameter int SS_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(SS_DEPTH)-1:0] waddr,
    input  logic [DSZ-1:0]              wdata,
    input  logic [$clog2(SS_DEPTH)-1:0] raddr,
    output logic [DSZ-1:0]              rdata
);

    logic [DSZ-1:0] mem [SS_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ej32_dstack.sv
// eJ32 data stack: NOS held in a register, deeper entries spilled to a sync-read RAM,
// with depth tracking, sticky overflow/underflow flags and optional circular overflow.
module ej32_dstack
    import ej32_pkg::*;
#(
    parameter int DSZ      = 32,
    parameter int SS_DEPTH = 32,
    parameter int WRAP     = WRAP_DROP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  stack_op_t                     op,
    input  logic [DSZ-1:0]                t_i,
    input  logic                          err_clr,
    output logic [DSZ-1:0]                s_o,
    output logic [$clog2(SS_DEPTH+1)-1:0] depth_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          ovf_o,
    output logic                          unf_o
);

    localparam int AW = $clog2(SS_DEPTH);
    localparam int DW = $clog2(SS_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(SS_DEPTH);

    logic [AW-1:0]  wp, wp_next, rd_addr;
    logic [DW-1:0]  depth, depth_next;
    logic [DSZ-1:0] nos, nos_next, rd_q, byp_q, third;
    logic           byp_vld, wr_en, full, empty;
    logic           ovf, unf, ovf_set, unf_set;

    assign full    = (depth == DEPTH_MAX);
    assign empty   = (depth == '0);
    // The RAM returns stale data right after a write to the slot it is reading.
    assign third   = byp_vld ? byp_q : rd_q;
    assign rd_addr = wp_next - AW'(1);

    always_comb begin
        wp_next    = wp;
        depth_next = depth;
        nos_next   = nos;
        wr_en      = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (en) begin
            unique case (op)
                sMOVE: nos_next = t_i;
                sPUSH: begin
                    if (full && (WRAP != WRAP_CIRC)) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        nos_next = t_i;
                        wp_next  = wp + AW'(1);
                        ovf_set  = full;
                        if (!full) begin
                            depth_next = depth + DW'(1);
                        end
                    end
                end
                sPOP: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else if (depth == DW'(1)) begin
                        nos_next   = '0;
                        depth_next = '0;
                    end else begin
                        nos_next   = third;
                        wp_next    = wp - AW'(1);
                        depth_next = depth - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    ej32_ss_ram #(
        .DSZ      (DSZ),
        .SS_DEPTH (SS_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wp),
        .wdata (nos),
        .raddr (rd_addr),
        .rdata (rd_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            nos     <= '0;
            wp      <= '0;
            depth   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            byp_vld <= 1'b0;
            byp_q   <= '0;
        end else begin
            nos     <= nos_next;
            wp      <= wp_next;
            depth   <= depth_next;
            byp_vld <= wr_en;
            if (wr_en) begin
                byp_q <= nos;
            end
            // A fresh error wins over a simultaneous clear.
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end

    assign s_o     = nos;
    assign depth_o = depth;
    assign full_o  = full;
    assign empty_o = empty;
    assign ovf_o   = ovf;
    assign unf_o   = unf;

endmodule

// File: tb/tb_ej32_dstack.sv
// Scoreboard bench: three stack configurations driven in lockstep, each checked against a queue-based model.
module tb_ej32_dstack;
    import ej32_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    stack_op_t   op;
    logic [31:0] t_i;
    logic        err_clr;

    logic [31:0] s0, s1, s2;
    logic [5:0]  depth0;
    logic [2:0]  depth1, depth2;
    logic        full0, full1, full2, empty0, empty1, empty2;
    logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;

    ej32_dstack #(.DSZ(32), .SS_DEPTH(32), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .op(op), .t_i(t_i), .err_clr(err_clr),
        .s_o(s0), .depth_o(depth0), .full_o(full0), .empty_o(empty0), .ovf_o(ovf0), .unf_o(unf0));
    ej32_dstack #(.DSZ(32), .SS_DEPTH(4), .WRAP(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .op(op), .t_i(t_i), .err_clr(err_clr),
        .s_o(s1), .depth_o(depth1), .full_o(full1), .empty_o(empty1), .ovf_o(ovf1), .unf_o(unf1));
    ej32_dstack #(.DSZ(32), .SS_DEPTH(4), .WRAP(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .op(op), .t_i(t_i), .err_clr(err_clr),
        .s_o(s2), .depth_o(depth2), .full_o(full2), .empty_o(empty2), .ovf_o(ovf2), .unf_o(unf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] s;
        logic [5:0]  depth;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   step_no = 0;

    localparam int MAXD [3] = '{32, 4, 4};
    localparam bit WRP  [3] = '{1'b0, 1'b0, 1'b1};

    // Reference model: NOS plus a queue of deeper entries, front = next below NOS.
    logic [31:0] m_nos   [3];
    int          m_depth [3];
    logic [31:0] m_below [3][$];
    logic        m_ovf   [3];
    logic        m_unf   [3];

    task automatic model_apply(input int k, input logic r, input logic e, input stack_op_t o,
                               input logic [31:0] t, input logic c);
        logic new_ovf, new_unf;
        logic [31:0] dummy;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (!r) begin
            m_nos[k] = '0;
            m_depth[k] = 0;
            m_below[k].delete();
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
            return;
        end
        if (e) begin
            case (o)
                sMOVE: m_nos[k] = t;
                sPUSH: begin
                    if (m_depth[k] == MAXD[k]) begin
                        new_ovf = 1'b1;
                        if (WRP[k]) begin
                            m_below[k].push_front(m_nos[k]);
                            dummy = m_below[k].pop_back();
                            m_nos[k] = t;
                        end
                    end else begin
                        if (m_depth[k] > 0) m_below[k].push_front(m_nos[k]);
                        m_nos[k] = t;
                        m_depth[k]++;
                    end
                end
                sPOP: begin
                    if (m_depth[k] == 0) begin
                        new_unf = 1'b1;
                    end else if (m_depth[k] == 1) begin
                        m_nos[k] = '0;
                        m_depth[k] = 0;
                    end else begin
                        m_nos[k] = m_below[k].pop_front();
                        m_depth[k]--;
                    end
                end
                default: ;
            endcase
        end
        if (c) begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
        if (new_ovf) m_ovf[k] = 1'b1;
        if (new_unf) m_unf[k] = 1'b1;
    endtask

    task automatic step(input logic r, input logic e, input stack_op_t o,
                        input logic [31:0] t, input logic c);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; op = o; t_i = t; err_clr = c;
        @(posedge clk);
        step_no++;
        for (int k = 0; k < 3; k++) begin
            model_apply(k, r, e, o, t, c);
            x.id    = 2'(k);
            x.s     = m_nos[k];
            x.depth = 6'(m_depth[k]);
            x.full  = (m_depth[k] == MAXD[k]);
            x.empty = (m_depth[k] == 0);
            x.ovf   = m_ovf[k];
            x.unf   = m_unf[k];
            exp_q.push_back(x);
        end
    endtask

    task automatic op1(input stack_op_t o, input logic [31:0] t);
        step(1'b1, 1'b1, o, t, 1'b0);
    endtask

    // Monitor: outputs are registered, so every posedge presents a result checked on the next negedge.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.id = e.id;
                case (e.id)
                    2'd0: begin a.s = s0; a.depth = depth0;      a.full = full0; a.empty = empty0; a.ovf = ovf0; a.unf = unf0; end
                    2'd1: begin a.s = s1; a.depth = 6'(depth1);  a.full = full1; a.empty = empty1; a.ovf = ovf1; a.unf = unf1; end
                    default: begin a.s = s2; a.depth = 6'(depth2); a.full = full2; a.empty = empty2; a.ovf = ovf2; a.unf = unf2; end
                endcase
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL dut%0d step %0d: got s=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, expected s=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                             e.id, step_no, a.s, a.depth, a.full, a.empty, a.ovf, a.unf,
                             e.s, e.depth, e.full, e.empty, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        int r;
        rst = 1'b0; en = 1'b0; op = sNOP; t_i = '0; err_clr = 1'b0;

        step(1'b0, 1'b0, sNOP, 32'h0, 1'b0);
        step(1'b0, 1'b1, sPUSH, 32'hdead, 1'b0);

        // basic push/pop, including pop at depth 1 and underflow at depth 0
        op1(sPUSH, 32'h11); op1(sPUSH, 32'h22); op1(sPUSH, 32'h33);
        repeat (4) op1(sPOP, 32'h0);
        op1(sMOVE, 32'h77);
        op1(sNOP, 32'h0);

        // push immediately followed by pop exercises the bypass register
        op1(sPUSH, 32'ha1); op1(sPUSH, 32'ha2);
        for (int i = 0; i < 100; i++) op1((i % 2 == 0) ? sPUSH : sPOP, $urandom);

        // overflow in both modes: 6 pushes then drain
        step(1'b0, 1'b0, sNOP, 32'h0, 1'b0);
        for (int i = 1; i <= 6; i++) op1(sPUSH, 32'(i));
        repeat (5) op1(sPOP, 32'h0);

        // flag clear semantics
        step(1'b1, 1'b1, sPOP, 32'h0, 1'b1);
        step(1'b1, 1'b0, sPOP, 32'h0, 1'b1);
        step(1'b1, 1'b0, sPUSH, 32'h55, 1'b0);
        op1(sMOVE, 32'h99);

        // reset in the middle of a push burst
        for (int i = 0; i < 5; i++) op1(sPUSH, $urandom);
        step(1'b0, 1'b1, sPUSH, 32'hbad, 1'b0);
        op1(sNOP, 32'h0);

        // fill the deep configuration past full, then drain past empty
        for (int i = 0; i < 36; i++) op1(sPUSH, $urandom);
        for (int i = 0; i < 35; i++) op1(sPOP, 32'h0);

        // random mix
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(199, 0);
            step((r != 0), ($urandom_range(7, 0) != 0), stack_op_t'($urandom_range(3, 0)),
                 $urandom, ($urandom_range(15, 0) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
